// File: rtl/uart_rx.sv
// 8N1 serial receiver with a first-word-fall-through receive FIFO.
// Bytes leave on a valid/ready interface; everything runs on clk.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LOAD = 16'((CLKS_PER_BIT / 2) - 1);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic        rx_meta;
  logic        rxs;
  state_t      state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        busy_q;
  logic        frame_err_q;
  logic        overrun_q;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        accept;
  logic        cnt_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rs_rx;
      rxs     <= rx_meta;
    end
  end

  assign cnt_done = (clk_cnt == '0);
  assign push     = (state == STOP) && cnt_done && rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            clk_cnt <= HALF_LOAD;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_done) begin
            if (rxs) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
              clk_cnt <= FULL_LOAD;
            end
          end else begin
            clk_cnt <= clk_cnt - 16'd1;
          end
        end
        DATA: begin
          if (cnt_done) begin
            shreg   <= {rxs, shreg[7:1]};
            clk_cnt <= FULL_LOAD;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt - 16'd1;
          end
        end
        STOP: begin
          if (cnt_done) begin
            if (rxs) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state       <= WAIT_HIGH;
              frame_err_q <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt - 16'd1;
          end
        end
        WAIT_HIGH: begin
          // a held-low line (break) must not be decoded as 0x00 frames
          if (rxs) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop    = !empty && rx_ready;
  // a pop in the same cycle frees the slot the full FIFO would otherwise refuse
  assign accept = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && full && !pop;
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr[AW-1:0]] <= shreg;
    end
  end

  assign rx_valid  = !empty;
  assign rx_data   = rx_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the `rs_rx` pin of the top level: it recovers 8N1 frames and buffers the received bytes in a small first-word-fall-through FIFO. It presents bytes to the `puter` core through a valid/ready interface and runs entirely in the system clock domain. It is the upstream stage for the core's serial input path; bytes leave on `rx_data` / `rx_valid` / `rx_ready`.

## Interface

- `CLKS_PER_BIT`, 434: system clocks per bit period (50 MHz / 115200); legal range 4..65535.
- `FIFO_DEPTH`, 4: receive buffer entries; power of two, at least 2.

- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rs_rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  byte at the FIFO head; valid only while `rx_valid` is high.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head byte this cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: complete byte dropped because the FIFO was full.
- `busy`  out  1  high whenever the receiver FSM is not in IDLE.

## Operation

- **Input conditioning.** `rs_rx` passes through a 2-flop synchroniser (`rxs`). Both flops reset to 1.
- **FSM states and transitions.** States are IDLE, START, DATA, STOP and WAIT_HIGH. One bit counter (3 bits) and one clock counter (16 bits) are shared across states.
  - IDLE: on `rxs`=0 (falling edge relative to idle high), go to START and load the clock counter.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample `rxs`.
    - If high, treat it as a glitch and return to IDLE with no pulse.
    - If low, go to DATA with bit counter = 0.
  - DATA: every CLKS_PER_BIT cycles, sample `rxs` into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxs`.
    - If 1, push the byte and go to IDLE.
    - If 0, pulse `frame_err`, discard the byte and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.
- **FIFO.** Storage is a register array with read/write pointers of log2(FIFO_DEPTH)+1 bits; wrap is detected on the MSB.
  - Empty: pointers are equal.
  - Full: indices are equal and MSBs differ.
  - Head output: `rx_data` = mem[rd_ptr]; `rx_valid` = !empty.
- **Pop.** A pop occurs when `rx_valid && rx_ready`. `rx_ready` while empty has no effect.
- **Push when full, no pop that cycle.** The byte is dropped, `overrun` pulses, and FIFO contents are unchanged.
- **Push and pop in the same cycle.**
  - FIFO full: the pop frees the slot, the push is accepted, and there is no overrun.
  - FIFO empty: no pop can occur (`rx_valid` is low); the push is accepted.
- **Reset.** Asserting `rst` at any time, including mid-frame, aborts the frame immediately.
  - FSM returns to IDLE and both pointers clear.
  - All outputs go to 0: `rx_valid`, `frame_err`, `overrun`, `busy`, and `rx_data` (memory is not cleared; `rx_data` is don't-care while `rx_valid`=0).
  - After release, a frame already in progress on the line is received only from its next falling edge found in IDLE.

## Timing

- **Input latency.** Pin to `rxs` is 2 cycles.
- **Sample points.** Let cycle 0 be the first cycle `rxs`=0 is seen in IDLE. With H = CLKS_PER_BIT/2:
  - start sample at cycle H;
  - data bit i sampled at H + (i+1)·CLKS_PER_BIT;
  - stop sample at H + 9·CLKS_PER_BIT.
- **Stop-sample effects.** The push, `frame_err` and `overrun` take effect on the clock edge ending the stop-sample cycle. `rx_valid` rises one cycle after that stop sample.
- **Back-to-back frames.** The FSM is in IDLE one cycle after the stop sample. This is mid-stop-bit, so a start bit immediately following the stop bit is caught with ≥ H cycles margin.
- **Pop latency.** A pop updates `rx_data` / `rx_valid` on the next cycle.
- **`busy` timing.** `busy` rises the cycle after the edge is detected and falls when the FSM re-enters IDLE.

## Test plan

All scenarios use CLKS_PER_BIT=16 and FIFO_DEPTH=4.

- **Single byte.** Send 0xA5 with `rx_ready`=0 → `rx_valid` rises at cycle 8+9·16+1 after edge detect, `rx_data`=0xA5; pulse `rx_ready` → `rx_valid`=0 next cycle.
- **Back-to-back and overrun.** Send 0x00, 0xFF, 0x55, 0x3C, 0x81 back-to-back with `rx_ready`=0 → the first four bytes are queued in order; `overrun` pulses once on the fifth; popping yields 0x00, 0xFF, 0x55, 0x3C, then `rx_valid`=0.
- **Framing error and break.** Send 0x12 with stop bit = 0, then hold the line low 40 bit times → one `frame_err` pulse, FIFO unchanged, no further frames decoded; the next valid 0x34 is received normally.
- **Glitch rejection.** Drive a 4-cycle low glitch on `rs_rx` → the FSM returns to IDLE at the start sample; no `rx_valid`, no `frame_err`.
- **Full FIFO with simultaneous pop.** With the FIFO full, assert `rx_ready` in the exact cycle a fifth byte 0x77 completes → no `overrun`; the last entry read is 0x77.
- **Reset mid-frame.** Assert `rst` during data bit 3 with 2 bytes queued → all outputs are 0 and the FIFO is empty; after release, 0xC3 sent cleanly is received.
